// File: rtl/cordic_job_sequencer.sv
// Job sequencer that feeds two requesters into one iterative CORDIC datapath.
// Define CORDIC_SEQ_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0).
module cordic_job_sequencer #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_ITER  = 8
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*BIT_WIDTH-1:0] req_x,
    input  logic [2*BIT_WIDTH-1:0] req_y,
    input  logic [2*BIT_WIDTH-1:0] req_z,
    input  logic [1:0]             req_mode,
    input  logic [3:0]             req_coord,

    output logic                   dp_load,
    output logic [BIT_WIDTH-1:0]   dp_x_init,
    output logic [BIT_WIDTH-1:0]   dp_y_init,
    output logic [BIT_WIDTH-1:0]   dp_z_init,
    output logic                   dp_mode,
    output logic [1:0]             dp_coord,
    output logic [5:0]             dp_iter,
    input  logic [BIT_WIDTH-1:0]   dp_x,
    input  logic [BIT_WIDTH-1:0]   dp_y,
    input  logic [BIT_WIDTH-1:0]   dp_z,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic                   rsp_err,
    output logic [BIT_WIDTH-1:0]   rsp_x,
    output logic [BIT_WIDTH-1:0]   rsp_y,
    output logic [BIT_WIDTH-1:0]   rsp_z,

    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(NUM_ITER - 1);
    localparam logic [1:0] COORD_ILLEGAL = 2'b11;

    state_t state;
    state_t state_nxt;

    logic                 take;
    logic                 grant_id;
    logic                 last_iter;
    logic                 sel_illegal;

    logic [BIT_WIDTH-1:0] sel_x;
    logic [BIT_WIDTH-1:0] sel_y;
    logic [BIT_WIDTH-1:0] sel_z;
    logic                 sel_mode;
    logic [1:0]           sel_coord;

    logic [BIT_WIDTH-1:0] job_x;
    logic [BIT_WIDTH-1:0] job_y;
    logic [BIT_WIDTH-1:0] job_z;
    logic                 job_mode;
    logic [1:0]           job_coord;
    logic                 job_id;

    logic [5:0]           iter_cnt;
    logic [BIT_WIDTH-1:0] res_x;
    logic [BIT_WIDTH-1:0] res_y;
    logic [BIT_WIDTH-1:0] res_z;
    logic                 res_err;

    // Arbitration: grant_id names the requester that wins this IDLE cycle.
`ifdef CORDIC_SEQ_RR_EN
    logic last_id;

    always_comb begin
        if (&req_valid) grant_id = ~last_id;
        else            grant_id = req_valid[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      last_id <= 1'b1;
        else if (take) last_id <= grant_id;
    end
`else
    assign grant_id = ~req_valid[0];
`endif

    assign take      = (state == IDLE) && (req_valid != 2'b00);
    // Gated by rst so the grant stays low while reset is held, even with requests pending.
    assign req_ready = (take && rst) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    assign sel_x       = grant_id ? req_x[2*BIT_WIDTH-1:BIT_WIDTH] : req_x[BIT_WIDTH-1:0];
    assign sel_y       = grant_id ? req_y[2*BIT_WIDTH-1:BIT_WIDTH] : req_y[BIT_WIDTH-1:0];
    assign sel_z       = grant_id ? req_z[2*BIT_WIDTH-1:BIT_WIDTH] : req_z[BIT_WIDTH-1:0];
    assign sel_mode    = grant_id ? req_mode[1] : req_mode[0];
    assign sel_coord   = grant_id ? req_coord[3:2] : req_coord[1:0];
    assign sel_illegal = (sel_coord == COORD_ILLEGAL);
    assign last_iter   = (iter_cnt == LAST_ITER);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: if (take)      state_nxt = sel_illegal ? RESP : LOAD;
            LOAD:                state_nxt = ITER;
            ITER: if (last_iter) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // NOTE: job registers drive outputs directly, so they are reset to keep every output at 0 in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            job_x     <= '0;
            job_y     <= '0;
            job_z     <= '0;
            job_mode  <= 1'b0;
            job_coord <= 2'b00;
            job_id    <= 1'b0;
        end else if (take) begin
            job_x     <= sel_x;
            job_y     <= sel_y;
            job_z     <= sel_z;
            job_mode  <= sel_mode;
            job_coord <= sel_coord;
            job_id    <= grant_id;
        end
    end

    // Iteration counter and result capture; an illegal job gets a zero result at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt <= '0;
            res_x    <= '0;
            res_y    <= '0;
            res_z    <= '0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        iter_cnt <= '0;
                        res_err  <= sel_illegal;
                        if (sel_illegal) begin
                            res_x <= '0;
                            res_y <= '0;
                            res_z <= '0;
                        end
                    end
                end
                ITER: begin
                    if (last_iter) begin
                        iter_cnt <= '0;
                        res_x    <= dp_x;
                        res_y    <= dp_y;
                        res_z    <= dp_z;
                    end else begin
                        iter_cnt <= iter_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp_load   = (state == LOAD);
    assign dp_iter   = iter_cnt;
    assign dp_x_init = job_x;
    assign dp_y_init = job_y;
    assign dp_z_init = job_z;
    assign dp_mode   = job_mode;
    assign dp_coord  = job_coord;

    assign rsp_valid = (state == RESP);
    assign rsp_id    = job_id;
    assign rsp_err   = res_err;
    assign rsp_x     = res_x;
    assign rsp_y     = res_y;
    assign rsp_z     = res_z;

    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Directed bench for cordic_job_sequencer with a toy datapath: x+=1, y+=iter, z-=1 (mode 0) or z+=2 (mode 1).
// Expected grant order follows CORDIC_SEQ_RR_EN when the bench is compiled with it.
module tb_cordic_job_sequencer;

    localparam int BW = 8;
    localparam int NI = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [2*BW-1:0] req_x = '0;
    logic [2*BW-1:0] req_y = '0;
    logic [2*BW-1:0] req_z = '0;
    logic [1:0]    req_mode = '0;
    logic [3:0]    req_coord = '0;
    logic          dp_load;
    logic [BW-1:0] dp_x_init, dp_y_init, dp_z_init;
    logic          dp_mode;
    logic [1:0]    dp_coord;
    logic [5:0]    dp_iter;
    logic [BW-1:0] dx = '0, dy = '0, dz = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id, rsp_err;
    logic [BW-1:0] rsp_x, rsp_y, rsp_z;
    logic          busy;
    logic [63:0]   all_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_job_sequencer #(.BIT_WIDTH(BW), .NUM_ITER(NI)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .req_mode(req_mode), .req_coord(req_coord),
        .dp_load(dp_load), .dp_x_init(dp_x_init), .dp_y_init(dp_y_init), .dp_z_init(dp_z_init),
        .dp_mode(dp_mode), .dp_coord(dp_coord), .dp_iter(dp_iter),
        .dp_x(dx), .dp_y(dy), .dp_z(dz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .busy(busy)
    );

    assign all_out = {req_ready, dp_load, dp_x_init, dp_y_init, dp_z_init, dp_mode, dp_coord,
                      dp_iter, rsp_valid, rsp_id, rsp_err, rsp_x, rsp_y, rsp_z, busy};

    // Toy datapath registers: load on dp_load, step once per ITER cycle.
    always @(posedge clk) begin
        if (dp_load) begin
            dx <= dp_x_init;
            dy <= dp_y_init;
            dz <= dp_z_init;
        end else if (busy && !rsp_valid) begin
            dx <= dx + 8'd1;
            dy <= dy + 8'(dp_iter);
            dz <= dp_mode ? dz + 8'd2 : dz - 8'd1;
        end
    end

    // edges = clock edges after the handshake edge until rsp_valid is seen.
    typedef struct {
        int         id;
        logic [7:0] x, y, z;
        logic       mode;
        logic [1:0] coord;
        logic       err;
        logic [7:0] ex, ey, ez;
        int         edges;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_job(input vec_t v, output int edges, output int loads, output bit seq_ok);
        int w;
        @(negedge clk);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_x[v.id*BW +: BW] = v.x;
        req_y[v.id*BW +: BW] = v.y;
        req_z[v.id*BW +: BW] = v.z;
        req_mode[v.id] = v.mode;
        req_coord[v.id*2 +: 2] = v.coord;
        #1;
        w = 0;
        while (req_ready[v.id] !== 1'b1 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check($sformatf("grant wait id%0d", v.id), (w < 50) ? 64'd1 : 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        edges  = 0;
        loads  = 0;
        seq_ok = 1'b1;
        while (rsp_valid !== 1'b1 && edges < 40) begin
            if (dp_load === 1'b1) loads++;
            if (edges == 0) begin
                if (dp_load !== 1'b1 || dp_iter !== 6'd0) seq_ok = 1'b0;
            end else if (dp_load !== 1'b0 || dp_iter !== 6'(edges - 1)) begin
                seq_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_rsp(input vec_t v, input int edges, input int loads, input bit seq_ok, input string tag);
        check({tag, " edges"}, 64'(edges), 64'(v.edges));
        check({tag, " id/err"}, {rsp_id, rsp_err}, {1'(v.id), v.err});
        check({tag, " rsp_xyz"}, {rsp_x, rsp_y, rsp_z}, {v.ex, v.ey, v.ez});
        check({tag, " load count"}, 64'(loads), v.err ? 64'd0 : 64'd1);
        check({tag, " iter seq"}, 64'(seq_ok), 64'd1);
        check({tag, " held job"}, {dp_x_init, dp_y_init, dp_z_init, dp_mode, dp_coord},
              {v.x, v.y, v.z, v.mode, v.coord});
    endtask

    task automatic release_rsp(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " idle after ready"}, {busy, rsp_valid}, 2'b00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   edges, loads, w, n;
        bit   ok;
        int   g[4];
        int   exp_g[4];

        vecs[0] = '{0,  10,  20,  30, 0, 0, 0,  17,  41,  23, 9};
        vecs[1] = '{1, 250, 240,   3, 1, 1, 0,   1,   5,  17, 9};
        vecs[2] = '{0,   0,   0,   0, 0, 2, 0,   7,  21, 249, 9};
        vecs[3] = '{1,   5,   6,   7, 0, 3, 1,   0,   0,   0, 0};
        vecs[4] = '{0, 255, 235, 128, 1, 3, 1,   0,   0,   0, 0};
        vecs[5] = '{1, 100, 200,  50, 1, 2, 0, 107, 221,  64, 9};
`ifdef CORDIC_SEQ_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif

        // Reset held with both requests pending: every output must stay 0.
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", all_out, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;

        for (int i = 0; i < 6; i++) begin
            start_job(vecs[i], edges, loads, ok);
            check_rsp(vecs[i], edges, loads, ok, $sformatf("vec%0d", i));
            release_rsp($sformatf("vec%0d", i));
        end

        // Backpressure with a new request waiting behind the response.
        v = '{0, 1, 2, 3, 0, 1, 0, 8, 23, 252, 9};
        start_job(v, edges, loads, ok);
        check_rsp(v, edges, loads, ok, "bp");
        @(negedge clk);
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp valid/ready", {rsp_valid, req_ready}, 3'b100);
            check("bp data", {rsp_id, rsp_err, rsp_x, rsp_y, rsp_z, dp_x_init},
                  {1'b0, 1'b0, 8'd8, 8'd23, 8'd252, 8'd1});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp next grant", {busy, req_ready}, 3'b001);
        @(posedge clk);
        #1;
        req_valid = '0;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("bp queued edges", 64'(w), 64'd9);
        check("bp queued rsp", {rsp_x, rsp_y, rsp_z}, {8'd8, 8'd23, 8'd252});
        release_rsp("bp queued");

        // Reset in the middle of ITER at dp_iter == 3.
        @(negedge clk);
        req_valid = 2'b01;
        req_x[7:0] = 8'd9;
        req_y[7:0] = 8'd9;
        req_z[7:0] = 8'd9;
        req_mode[0] = 1'b0;
        req_coord[1:0] = 2'd0;
        @(posedge clk);
        #1;
        req_valid = '0;
        w = 0;
        while (!(dp_iter == 6'd3 && busy && !dp_load) && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("reach iter 3", (w < 40) ? 64'd1 : 64'd0, 64'd1);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        check("mid-job reset outputs", all_out, 64'd0);
        @(posedge clk);
        #1;
        check("mid-job reset held", all_out, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("after mid reset idle", {busy, rsp_valid}, 2'b00);
        v = '{0, 40, 50, 60, 1, 1, 0, 47, 71, 74, 9};
        start_job(v, edges, loads, ok);
        check_rsp(v, edges, loads, ok, "post-reset");
        release_rsp("post-reset");

        // Contention: both requesters valid for four jobs, consumer always ready.
        do_reset();
        req_valid = 2'b11;
        req_coord = 4'b0000;
        rsp_ready = 1'b1;
        g = '{-1, -1, -1, -1};
        #1;
        n = 0;
        w = 0;
        while (n < 4 && w < 200) begin
            if (req_ready != 2'b00) begin
                g[n] = int'(req_ready[1]);
                n++;
            end
            if (n < 4) begin
                @(negedge clk);
                #1;
            end
            w++;
        end
        check("contention grants", 64'(n), 64'd4);
        for (int k = 0; k < 4; k++) check($sformatf("grant %0d", k), 64'(g[k]), 64'(exp_g[k]));
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        w = 0;
        while (req_ready[1] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("waiting req1 served", (w < 100) ? 64'd1 : 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        w = 0;
        while (busy !== 1'b0 && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain to idle", (w < 40) ? 64'd1 : 64'd0, 64'd1);
        rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
